// File: rtl/weight_pkg.sv
// rtl/weight_pkg.sv - shared widths, limits and saturation helper for the weight pipeline
package weight_pkg;
   localparam int RAW_W  = 24;
   localparam int NET_W  = 25;
   localparam int PROD_W = 41;
   localparam logic [RAW_W-1:0] WEIGHT_MAX = 24'h7FFFFF;
   localparam logic [RAW_W-1:0] WEIGHT_MIN = 24'h800000;
   localparam logic signed [PROD_W-1:0] SAT_HI = 41'sd8388607;
   localparam logic signed [PROD_W-1:0] SAT_LO = -41'sd8388608;

   function automatic logic [RAW_W-1:0] sat_weight(input logic signed [PROD_W-1:0] v);
      if (v > SAT_HI)
         return WEIGHT_MAX;
      else if (v < SAT_LO)
         return WEIGHT_MIN;
      else
         return v[RAW_W-1:0];
   endfunction
endpackage

// File: rtl/avg_ring.sv
// rtl/avg_ring.sv - 2^AVG_LOG2-deep ring buffer with running sum, fill counter and primed flag
module avg_ring
   import weight_pkg::*;
#(
   parameter int AVG_LOG2 = 3
) (
   input  logic             clk_50,
   input  logic             rst_n,
   input  logic [RAW_W-1:0] raw_data,
   input  logic             raw_valid,
   output logic [RAW_W-1:0] avg,
   output logic             avg_valid,
   output logic             primed
);
   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = RAW_W + AVG_LOG2;

   logic [RAW_W-1:0]    ring [DEPTH];
   logic [AVG_LOG2-1:0] ptr;
   logic [AVG_LOG2:0]   fill;
   logic [SUM_W-1:0]    sum;
   logic [SUM_W-1:0]    old_ext;
   logic [SUM_W-1:0]    new_ext;

   assign old_ext = {{AVG_LOG2{ring[ptr][RAW_W-1]}}, ring[ptr]};
   assign new_ext = {{AVG_LOG2{raw_data[RAW_W-1]}}, raw_data};

   // Dropping the low bits of the two's-complement sum is a floor divide.
   assign avg    = sum[SUM_W-1:AVG_LOG2];
   assign primed = (fill == (AVG_LOG2 + 1)'(DEPTH));

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            ring[i] <= '0;
         ptr       <= '0;
         fill      <= '0;
         sum       <= '0;
         avg_valid <= 1'b0;
      end else begin
         avg_valid <= raw_valid;
         if (raw_valid) begin
            sum       <= sum - old_ext + new_ext;
            ring[ptr] <= raw_data;
            ptr       <= ptr + 1'b1;
            if (!primed)
               fill <= fill + 1'b1;
         end
      end
   end
endmodule

// File: rtl/weight_proc.sv
// rtl/weight_proc.sv - averaged, tared, scaled weight with stability detect
// Optional: WEIGHT_NEG_CLAMP_EN outputs negative results as zero.
module weight_proc
   import weight_pkg::*;
#(
   parameter int AVG_LOG2    = 3,
   parameter int SCALE_MUL   = 1024,
   parameter int SCALE_SHIFT = 10,
   parameter int STABLE_TOL  = 16,
   parameter int STABLE_CNT  = 4
) (
   input  logic        clk_50,
   input  logic        rst_n,
   input  logic [23:0] raw_data,
   input  logic        raw_valid,
   input  logic        tare_req,
   output logic [23:0] weight,
   output logic        weight_valid,
   output logic        stable,
   output logic        tare_done,
   output logic        primed
);
   localparam int CNT_W = $clog2(STABLE_CNT + 1);
   localparam logic [15:0] MUL16 = 16'(SCALE_MUL);

   logic [RAW_W-1:0]         avg;
   logic                     avg_valid;
   logic [RAW_W-1:0]         tare_val;
   logic [RAW_W-1:0]         prev_avg;
   logic                     have_prev;
   logic                     tare_pend;
   logic [CNT_W-1:0]         steady_cnt;
   logic                     s2_valid;
   logic                     s2_tare;
   logic signed [NET_W-1:0]  s2_net;
   logic                     s1_go;
   logic                     consume;
   logic signed [NET_W-1:0]  diff;
   logic signed [NET_W-1:0]  diff_abs;
   logic                     steady;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] res;
   logic [RAW_W-1:0]         sat;
   logic [RAW_W-1:0]         w_next;

   avg_ring #(.AVG_LOG2(AVG_LOG2)) u_ring (
      .clk_50    (clk_50),
      .rst_n     (rst_n),
      .raw_data  (raw_data),
      .raw_valid (raw_valid),
      .avg       (avg),
      .avg_valid (avg_valid),
      .primed    (primed)
   );

   // A tare request landing on the same stage-1 result is consumed immediately.
   assign s1_go    = avg_valid & primed;
   assign consume  = s1_go & (tare_pend | tare_req);
   assign diff     = $signed({avg[RAW_W-1], avg}) - $signed({prev_avg[RAW_W-1], prev_avg});
   assign diff_abs = diff[NET_W-1] ? -diff : diff;
   assign steady   = (diff_abs <= NET_W'(STABLE_TOL));

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         tare_val   <= '0;
         tare_pend  <= 1'b0;
         prev_avg   <= '0;
         have_prev  <= 1'b0;
         steady_cnt <= '0;
         s2_valid   <= 1'b0;
         s2_tare    <= 1'b0;
         s2_net     <= '0;
      end else begin
         s2_valid <= s1_go;
         s2_tare  <= consume;
         if (consume)
            tare_pend <= 1'b0;
         else if (tare_req)
            tare_pend <= 1'b1;
         if (s1_go) begin
            if (consume) begin
               tare_val <= avg;
               s2_net   <= '0;
            end else begin
               s2_net <= $signed({avg[RAW_W-1], avg}) - $signed({tare_val[RAW_W-1], tare_val});
            end
            if (!have_prev)
               steady_cnt <= '0;
            else if (steady) begin
               if (steady_cnt != CNT_W'(STABLE_CNT))
                  steady_cnt <= steady_cnt + 1'b1;
            end else
               steady_cnt <= '0;
            prev_avg  <= avg;
            have_prev <= 1'b1;
         end
      end
   end

   assign prod = $signed({{(PROD_W-NET_W){s2_net[NET_W-1]}}, s2_net})
               * $signed({{(PROD_W-16){1'b0}}, MUL16});
   assign res  = prod >>> SCALE_SHIFT;
   assign sat  = sat_weight(res);
`ifdef WEIGHT_NEG_CLAMP_EN
   assign w_next = sat[RAW_W-1] ? '0 : sat;
`else
   assign w_next = sat;
`endif

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         weight       <= '0;
         weight_valid <= 1'b0;
         tare_done    <= 1'b0;
         stable       <= 1'b0;
      end else begin
         weight_valid <= s2_valid;
         tare_done    <= s2_valid & s2_tare;
         if (s2_valid) begin
            weight <= w_next;
            stable <= (steady_cnt == CNT_W'(STABLE_CNT));
         end
      end
   end
endmodule

// File: tb/tb_weight_proc.sv
// tb/tb_weight_proc.sv - self-checking bench for weight_proc against a sample-history model
module tb_weight_proc;
   localparam int N    = 8;
   localparam int TOL  = 16;
   localparam int SCNT = 4;

   typedef struct {
      int          due;
      logic [23:0] w;
      logic        st;
      logic        td;
   } exp_t;

   logic        clk_50 = 1'b0;
   logic        rst_n;
   logic [23:0] raw_data;
   logic        raw_valid;
   logic        tare_req;
   logic [23:0] weight;
   logic        weight_valid;
   logic        stable;
   logic        tare_done;
   logic        primed;

   logic [23:0] s_raw;
   logic        s_valid;
   logic        s_tare;
   logic [23:0] s_weight;
   logic        s_wv;
   logic        s_stable;
   logic        s_td;
   logic        s_primed;

   weight_proc u_dut (
      .clk_50       (clk_50),
      .rst_n        (rst_n),
      .raw_data     (raw_data),
      .raw_valid    (raw_valid),
      .tare_req     (tare_req),
      .weight       (weight),
      .weight_valid (weight_valid),
      .stable       (stable),
      .tare_done    (tare_done),
      .primed       (primed)
   );

   weight_proc #(.SCALE_MUL(65535), .SCALE_SHIFT(0)) u_sat (
      .clk_50       (clk_50),
      .rst_n        (rst_n),
      .raw_data     (s_raw),
      .raw_valid    (s_valid),
      .tare_req     (s_tare),
      .weight       (s_weight),
      .weight_valid (s_wv),
      .stable       (s_stable),
      .tare_done    (s_td),
      .primed       (s_primed)
   );

   always #10 clk_50 = ~clk_50;

   int cyc = 0;
   always @(posedge clk_50) cyc <= cyc + 1;

   int          total = 0;
   int          bad = 0;
   int          out_cnt = 0;
   logic [23:0] last_w;
   logic        last_st;
   logic        last_td;

   longint hist[$];
   exp_t   expq[$];
   longint m_tare;
   bit     m_pend;
   bit     m_have;
   longint m_prev;
   int     m_steady;

   function automatic logic [23:0] model_weight(input longint net, input longint mul, input int sh);
      longint r;
      r = (net * mul) >>> sh;
      if (r > 8388607) r = 8388607;
      if (r < -8388608) r = -8388608;
`ifdef WEIGHT_NEG_CLAMP_EN
      if (r < 0) r = 0;
`endif
      return 24'(r);
   endfunction

   task automatic model_reset();
      hist.delete();
      expq.delete();
      m_tare = 0; m_pend = 0; m_have = 0; m_prev = 0; m_steady = 0;
   endtask

   task automatic model_sample(input logic [23:0] v);
      longint s, a, d;
      exp_t   e;
      hist.push_back(longint'($signed(v)));
      if (hist.size() > N) void'(hist.pop_front());
      if (hist.size() < N) return;
      s = 0;
      foreach (hist[i]) s += hist[i];
      a = s / N;
      if ((s % N) != 0 && s < 0) a = a - 1;
      e.td = 1'b0;
      if (m_pend) begin
         m_tare = a; m_pend = 0; e.td = 1'b1;
      end
      d = (a > m_prev) ? a - m_prev : m_prev - a;
      if (!m_have) m_steady = 0;
      else if (d <= TOL) m_steady = (m_steady < SCNT) ? m_steady + 1 : SCNT;
      else m_steady = 0;
      m_prev = a; m_have = 1;
      e.w   = model_weight(a - m_tare, 1024, 10);
      e.st  = (m_steady == SCNT);
      e.due = cyc + 3;
      expq.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic cmp_loop();
      exp_t e;
      forever begin
         @(negedge clk_50);
         if (rst_n) begin
            if (weight_valid) begin
               total++;
               out_cnt++;
               last_w = weight; last_st = stable; last_td = tare_done;
               if (expq.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_valid cyc=%0d got=%h", cyc, weight);
               end else begin
                  e = expq.pop_front();
                  if (e.due != cyc || weight !== e.w || stable !== e.st || tare_done !== e.td) begin
                     bad++;
                     $display("FAIL stream cyc=%0d got w=%h st=%b td=%b exp w=%h st=%b td=%b due=%0d",
                              cyc, weight, stable, tare_done, e.w, e.st, e.td, e.due);
                  end
               end
            end else begin
               if (expq.size() > 0 && expq[0].due < cyc) begin
                  total++;
                  bad++;
                  $display("FAIL missing_valid cyc=%0d exp w=%h due=%0d", cyc, expq[0].w, expq[0].due);
                  void'(expq.pop_front());
               end
               if (tare_done) begin
                  total++;
                  bad++;
                  $display("FAIL stray_tare_done cyc=%0d got=1 exp=0", cyc);
               end
            end
         end
      end
   endtask

   task automatic idle(input int g);
      for (int i = 0; i < g; i++) begin
         @(posedge clk_50); #1;
      end
   endtask

   task automatic drive(input logic [23:0] v);
      raw_data = v; raw_valid = 1'b1;
      model_sample(v);
      @(posedge clk_50); #1;
      raw_valid = 1'b0;
   endtask

   task automatic send(input logic [23:0] v, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         drive(v);
         idle(gap);
      end
   endtask

   task automatic tare_pulse();
      tare_req = 1'b1; m_pend = 1;
      @(posedge clk_50); #1;
      tare_req = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      idle(2);
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic sat_run(input logic [23:0] v, output int n, output logic [23:0] w);
      n = 0; w = '0;
      for (int i = 0; i < N; i++) begin
         s_raw = v; s_valid = 1'b1;
         @(posedge clk_50); #1;
      end
      s_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_50);
         if (s_wv) begin n++; w = s_weight; end
      end
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int          o, n;
      logic [23:0] w;
      rst_n = 1'b0; raw_data = '0; raw_valid = 1'b0; tare_req = 1'b0;
      s_raw = '0; s_valid = 1'b0; s_tare = 1'b0;
      model_reset();
      fork cmp_loop(); join_none
      idle(2);
      chk("rst_weight", 32'(weight), 32'd0);
      chk("rst_valid", 32'(weight_valid), 32'd0);
      chk("rst_stable", 32'(stable), 32'd0);
      chk("rst_tare_done", 32'(tare_done), 32'd0);
      chk("rst_primed", 32'(primed), 32'd0);
      rst_n = 1'b1;
      idle(1);

      // Priming: seven samples produce nothing, the eighth produces 1000.
      send(24'd1000, 7, 49);
      chk("prime_no_out", 32'(out_cnt), 32'd0);
      chk("prime_not_primed", 32'(primed), 32'd0);
      send(24'd1000, 1, 6);
      chk("prime_one_out", 32'(out_cnt), 32'd1);
      chk("prime_weight", 32'(last_w), 32'd1000);
      chk("prime_primed", 32'(primed), 32'd1);

      // Tare at 1000, then settle at 5219.
      tare_pulse();
      idle(3);
      send(24'd1000, 1, 6);
      chk("tare_done", 32'(last_td), 32'd1);
      chk("tare_weight", 32'(last_w), 32'd0);
      send(24'd5219, 8, 4);
      chk("tare_net", 32'(last_w), 32'd4219);
      chk("tare_done_clear", 32'(last_td), 32'd0);

      // Stability.
      do_reset();
      send(24'd62, 8, 3);
      send(24'd62, 3, 3);
      chk("stable_3rd", 32'(last_st), 32'd0);
      send(24'd62, 1, 5);
      chk("stable_4th", 32'(last_st), 32'd1);
      send(24'd198, 1, 5);
      chk("stable_jump", 32'(last_st), 32'd0);
      chk("stable_jump_w", 32'(last_w), 32'd79);

      // Negative weight.
      do_reset();
      send(24'hFFFF9C, 8, 3);
`ifdef WEIGHT_NEG_CLAMP_EN
      chk("neg_weight", 32'(last_w), 32'd0);
`else
      chk("neg_weight", 32'(last_w), 32'h00FFFF9C);
`endif

      // Reset in the middle of filling.
      do_reset();
      send(24'd300, 5, 2);
      do_reset();
      o = out_cnt;
      send(24'd300, 7, 2);
      chk("midrst_no_out", 32'(out_cnt), 32'(o));
      chk("midrst_primed", 32'(primed), 32'd0);
      send(24'd300, 1, 6);
      chk("midrst_first_out", 32'(out_cnt), 32'(o + 1));
      chk("midrst_weight", 32'(last_w), 32'd300);

      // Back-to-back stream with a pending tare.
      tare_pulse();
      for (int i = 0; i < 24; i++) begin
         int r;
         r = int'($urandom_range(0, 400));
         drive(24'(r - 200));
      end
      idle(8);
      chk("burst_drained", 32'(expq.size()), 32'd0);

      // Saturation on the high-gain instance.
      sat_run(24'h7FFFFF, n, w);
      chk("sat_hi_count", 32'(n), 32'd1);
      chk("sat_hi_weight", 32'(w), 32'h007FFFFF);
      sat_run(24'h800000, n, w);
`ifdef WEIGHT_NEG_CLAMP_EN
      chk("sat_lo_weight", 32'(w), 32'd0);
`else
      chk("sat_lo_weight", 32'(w), 32'h00800000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/weight_proc.md
Name: weight_proc

Overview:
- Downstream consumer of the HX711 serial reader (`ad`).
- Takes each completed 24-bit two's-complement conversion and applies a 2^AVG_LOG2-sample moving average, tare offset subtraction, fixed-point scaling to grams, and stability detection.
- Feeds the canteen price/display logic with a settled weight and a stable flag.

Parameters:
- AVG_LOG2, 3: moving-average depth is 2^AVG_LOG2 samples (legal 1..5).
- SCALE_MUL, 1024: unsigned 16-bit gram multiplier.
- SCALE_SHIFT, 10: arithmetic right shift applied after the multiply.
- STABLE_TOL, 16: maximum |avg - prev_avg| in raw counts that still counts as steady.
- STABLE_CNT, 4: number of consecutive steady results required before `stable` asserts.

Ports:
- clk_50  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- raw_data  input  24  signed conversion result from `ad` (value_last).
- raw_valid  input  1  one-cycle strobe; raw_data is valid in the same cycle.
- tare_req  input  1  one-cycle tare command from the key debouncer.
- weight  output  24  signed net weight in grams.
- weight_valid  output  1  one-cycle strobe qualifying weight and stable.
- stable  output  1  weight has settled.
- tare_done  output  1  one-cycle strobe when a new tare value is captured.
- primed  output  1  averaging buffer is full.

Behaviour:
- Reset values:
  - Outputs: weight=0, weight_valid=0, stable=0, tare_done=0, primed=0.
  - Internal state: tare register=0, ring buffer=0, sum=0, pointer=0, fill count=0, steady count=0, tare pending=0.
  - Reset asserted mid-stream discards all state, including tare; the in-flight pipeline is flushed.
- Ring averaging (stage 1, cycle after raw_valid):
  - sum <= sum - buf[ptr] + raw_data; buf[ptr] <= raw_data; ptr wraps modulo 2^AVG_LOG2.
  - sum width is 24+AVG_LOG2 bits, signed, sign-extended on add.
  - fill count saturates at 2^AVG_LOG2; primed=1 from the cycle fill reaches the limit.
  - avg = sum >>> AVG_LOG2 (arithmetic, rounds toward negative infinity).
- Pipeline:
  - stage 2: net = avg - tare, 25-bit signed.
  - stage 3: prod = net * SCALE_MUL (41-bit signed); res = prod >>> SCALE_SHIFT; saturate to [-8388608, 8388607].
  - weight_valid pulses exactly 3 cycles after an accepted raw_valid, only when primed was 1 at stage 1.
  - Samples arriving before priming update the buffer but produce no output.
  - Fully pipelined: raw_valid on consecutive cycles is accepted with no loss.
- Tare:
  - tare_req sets tare pending; pending persists until consumed.
  - Consumption happens at the next primed stage-1 result: tare <= avg, and that same sample flows through with net=0.
  - tare_done pulses in the same cycle as that sample's weight_valid.
  - tare_req coincident with a stage-1 result applies to that result.
  - Repeated tare_req while pending is a no-op.
- Stability (evaluated per primed result, at stage 2):
  - First primed result: steady count=0.
  - Otherwise, if |avg - prev_avg| <= STABLE_TOL, steady count increments, saturating at STABLE_CNT; else it clears to 0.
  - stable = (steady count == STABLE_CNT); it updates aligned with weight_valid.
  - A tare capture does not reset the steady count.

Optional Feature:
- Macro WEIGHT_NEG_CLAMP_EN.
- When defined: a negative saturated result is output as 0, so the scale never displays below zero.
- When undefined: negative weights pass through signed.

Decomposition:
- Package weight_pkg: RAW_W=24, NET_W=25, PROD_W=41, WEIGHT_MAX=24'h7FFFFF, WEIGHT_MIN=24'h800000, and the saturation helper function.
- Sub-module avg_ring: ring buffer, running sum, fill counter, primed output; parameterised by AVG_LOG2.
- Tare, scaling and stability stay in weight_proc.

Test Plan:
- Priming: reset, then 8 samples of 1000 spaced 50 clocks apart -> no weight_valid for samples 1-7; for sample 8, weight_valid 3 cycles after raw_valid with weight=1000 and primed=1.
- Tare: primed at 1000, pulse tare_req, then send 1000 -> tare_done with weight=0; then 8 samples of 5219 -> final weight=4219.
- Stability: primed at 62, 4 more samples of 62 -> stable=1 on the 4th output; then one sample of 198 (avg jumps 17) -> stable=0 on that output.
- Negative: 8 samples of 24'hFFFF9C -> weight=-100 (24'hFFFF9C); with WEIGHT_NEG_CLAMP_EN defined -> weight=0.
- Saturation: SCALE_MUL=65535, SCALE_SHIFT=0, 8 samples of 24'h7FFFFF -> weight=24'h7FFFFF; samples of 24'h800000 -> weight=24'h800000 (0 with clamp).
- Reset mid-fill: 5 samples, pulse rst_n low, then 7 samples -> no weight_valid and primed=0; the 8th sample after reset produces the first output.
